// File: rtl/uart_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_parser
// Function : Pops bytes from a first-word-fall-through UART Rx FIFO and
//            parses SOF / LEN / payload / XOR-checksum frames. Good payloads
//            are kept in a buffer read by address. One-cycle strobes report
//            good and aborted frames. An inter-byte timeout aborts stalled
//            frames.
// Option   : `define UART_PARSER_STATS_EN adds saturating 16-bit good, bad
//            and dropped-byte counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_parser #(
  parameter int                DBITS          = 8,
  parameter logic [DBITS-1:0]  SOF_BYTE       = 8'hA5,
  parameter int                MAX_LEN        = 16,
  parameter int                LEN_BITS       = 5,
  parameter int                ADDR_BITS      = 4,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter int                TO_BITS        = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_empty,
  input  logic [DBITS-1:0]     read_data,
  output logic                 read_uart,
  input  logic [ADDR_BITS-1:0] pl_addr,
  output logic [DBITS-1:0]     pl_data,
  output logic [LEN_BITS-1:0]  frame_len,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
`ifdef UART_PARSER_STATS_EN
  ,
  output logic [15:0]          good_cnt,
  output logic [15:0]          bad_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  localparam logic [1:0]         ERR_LEN   = 2'd1;
  localparam logic [1:0]         ERR_CHK   = 2'd2;
  localparam logic [1:0]         ERR_TO    = 2'd3;
  localparam logic [DBITS-1:0]   MAX_LEN_W = DBITS'(MAX_LEN);
  localparam logic [TO_BITS-1:0] TO_MAX    = TO_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DBITS-1:0]    byte_reg;
  logic                byte_vld;
  logic [LEN_BITS-1:0] len_q, len_nxt;
  logic [LEN_BITS-1:0] idx_q, idx_nxt;
  logic [DBITS-1:0]    chk_q, chk_nxt;
  logic [TO_BITS-1:0]  to_cnt, to_nxt, to_inc;
  logic                fv_nxt, fe_nxt;
  logic [1:0]          ec_nxt;
  logic [LEN_BITS-1:0] fl_nxt;
  logic                wr_en;
  logic                drop;

  logic [DBITS-1:0]    buf_mem [2**ADDR_BITS];

  // The byte popped last cycle is the one being processed this cycle.
  assign byte_vld = read_uart;
  assign busy     = (state != S_HUNT);
  assign pl_data  = buf_mem[pl_addr];

  // Pop handshake: capture the FIFO head together with the pop request,
  // never popping on two consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_uart <= 1'b0;
      byte_reg  <= '0;
    end else if (!rx_empty && !read_uart) begin
      read_uart <= 1'b1;
      byte_reg  <= read_data;
    end else begin
      read_uart <= 1'b0;
    end
  end

  // Frame state, datapath and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_len   <= '0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      idx_q       <= idx_nxt;
      chk_q       <= chk_nxt;
      to_cnt      <= to_nxt;
      frame_valid <= fv_nxt;
      frame_err   <= fe_nxt;
      err_code    <= ec_nxt;
      frame_len   <= fl_nxt;
    end
  end

  // Next-state logic: byte processing has priority over the timeout.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    idx_nxt   = idx_q;
    chk_nxt   = chk_q;
    fv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    ec_nxt    = err_code;
    fl_nxt    = frame_len;
    wr_en     = 1'b0;
    drop      = 1'b0;
    to_inc    = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_BITS'(1);
    to_nxt    = '0;
    if (busy && !byte_vld) begin
      to_nxt = to_inc;
    end

    if (byte_vld) begin
      case (state)
        S_HUNT: begin
          if (byte_reg == SOF_BYTE) begin
            state_nxt = S_LEN;
          end else begin
            drop = 1'b1;
          end
        end
        S_LEN: begin
          if ((byte_reg == '0) || (byte_reg > MAX_LEN_W)) begin
            fe_nxt    = 1'b1;
            ec_nxt    = ERR_LEN;
            state_nxt = S_HUNT;
          end else begin
            len_nxt   = byte_reg[LEN_BITS-1:0];
            chk_nxt   = byte_reg;
            idx_nxt   = '0;
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          wr_en   = 1'b1;
          chk_nxt = chk_q ^ byte_reg;
          idx_nxt = idx_q + LEN_BITS'(1);
          if (idx_q == (len_q - LEN_BITS'(1))) begin
            state_nxt = S_CHK;
          end
        end
        S_CHK: begin
          if (byte_reg == chk_q) begin
            fv_nxt = 1'b1;
            fl_nxt = len_q;
          end else begin
            fe_nxt = 1'b1;
            ec_nxt = ERR_CHK;
          end
          state_nxt = S_HUNT;
        end
        default: state_nxt = S_HUNT;
      endcase
    end else if (busy && (to_inc == TO_MAX)) begin
      fe_nxt    = 1'b1;
      ec_nxt    = ERR_TO;
      state_nxt = S_HUNT;
    end
  end

  // Payload buffer: written only while collecting payload, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[idx_q[ADDR_BITS-1:0]] <= byte_reg;
    end
  end

`ifdef UART_PARSER_STATS_EN
  // Saturating frame and dropped-byte statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fv_nxt && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
      if (fe_nxt && (bad_cnt  != 16'hFFFF)) bad_cnt  <= bad_cnt  + 16'd1;
      if (drop   && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_parser
// Function : Self-checking bench for uart_rx_frame_parser. A queue models
//            the Rx FIFO; a stream-level reference parser predicts the
//            sequence of frame events, lengths and payloads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_parser;

  localparam int TO = 100;

  typedef struct packed {
    logic [1:0]   code;   // 0 = good frame, else expected err_code
    logic [4:0]   len;    // expected frame_len at the strobe
    logic [127:0] pl;     // expected payload (good frames)
  } ev_t;

  logic       clk;
  logic       reset;
  logic       rx_empty;
  logic [7:0] read_data;
  logic       read_uart;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic [4:0] frame_len;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
`ifdef UART_PARSER_STATS_EN
  logic [15:0] good_cnt, bad_cnt, drop_cnt;
`endif

  uart_rx_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .read_data   (read_data),
    .read_uart   (read_uart),
    .pl_addr     (pl_addr),
    .pl_data     (pl_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
`ifdef UART_PARSER_STATS_EN
    ,
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  logic [7:0] fifo [$];
  logic [7:0] stream [$];
  ev_t        exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_pop = 0;
  int         pops     = 0;
  int         m_good   = 0;
  int         m_bad    = 0;
  int         m_drop   = 0;
  int         m_last_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic refresh();
    rx_empty  = (fifo.size() == 0);
    read_data = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic push_ev(input int code, input int len, input logic [127:0] pl);
    ev_t e;
    e.code = 2'(code);
    e.len  = 5'(len);
    e.pl   = pl;
    exp_q.push_back(e);
  endtask

  // Reference parser over a complete byte stream; a frame cut short by the
  // end of the stream is expected to end in a timeout.
  task automatic model();
    int i, n, len;
    logic [7:0]   x;
    logic [127:0] pl;
    i = 0;
    n = stream.size();
    while (i < n) begin
      if (stream[i] != 8'hA5) begin
        m_drop++;
        i++;
      end else if (i + 1 >= n) begin
        m_bad++;
        push_ev(3, m_last_len, '0);
        i = n;
      end else begin
        len = int'(stream[i+1]);
        if (len == 0 || len > 16) begin
          m_bad++;
          push_ev(1, m_last_len, '0);
          i += 2;
        end else if (i + 2 + len >= n) begin
          m_bad++;
          push_ev(3, m_last_len, '0);
          i = n;
        end else begin
          x  = 8'(len);
          pl = '0;
          for (int k = 0; k < len; k++) begin
            x ^= stream[i+2+k];
            pl[k*8 +: 8] = stream[i+2+k];
          end
          if (stream[i+2+len] == x) begin
            m_good++;
            m_last_len = len;
            push_ev(0, len, pl);
          end else begin
            m_bad++;
            push_ev(2, m_last_len, '0);
          end
          i += 3 + len;
        end
      end
    end
  endtask

  task automatic handle_event();
    ev_t e;
    logic [31:0] obs;
    check_eq("strobe_exclusive", {31'd0, frame_valid & frame_err}, 0);
    check_eq("busy_at_strobe", {31'd0, busy}, 0);
    if (exp_q.size() == 0) begin
      check_eq("unexpected_strobe", exp_q.size(), 1);
    end else begin
      e   = exp_q.pop_front();
      obs = frame_valid ? 32'd0 : {30'd0, err_code};
      check_eq("event_code", obs, {30'd0, e.code});
      check_eq("frame_len", {27'd0, frame_len}, {27'd0, e.len});
      if (frame_err && err_code == 2'd3) begin
        check_eq("timeout_latency", cyc - last_pop, TO);
      end
      if (frame_valid) begin
        for (int k = 0; k < int'(e.len); k++) begin
          pl_addr = 4'(k);
          #1;
          check_eq("payload", {24'd0, pl_data}, {24'd0, e.pl[k*8 +: 8]});
        end
      end
    end
  endtask

  task automatic cycle();
    logic [7:0] dummy;
    @(negedge clk);
    cyc++;
    if (read_uart) begin
      pops++;
      last_pop = cyc;
      if (fifo.size() > 0) dummy = fifo.pop_front();
    end
    if (frame_valid || frame_err) handle_event();
    refresh();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      cycle();
      if (fifo.size() == 0 && !read_uart && !busy) done = 1'b1;
    end
    repeat (4) cycle();
    check_eq("drain_done", {31'd0, done}, 1);
    check_eq("events_left", exp_q.size(), 0);
`ifdef UART_PARSER_STATS_EN
    check_eq("good_cnt", {16'd0, good_cnt}, m_good);
    check_eq("bad_cnt",  {16'd0, bad_cnt},  m_bad);
    check_eq("drop_cnt", {16'd0, drop_cnt}, m_drop);
`endif
  endtask

  task automatic run_stream(input int gap_max);
    model();
    foreach (stream[i]) begin
      fifo.push_back(stream[i]);
      refresh();
      repeat ($urandom_range(0, gap_max)) cycle();
    end
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read_uart"},   {31'd0, read_uart}, 0);
    check_eq({tag, "_frame_valid"}, {31'd0, frame_valid}, 0);
    check_eq({tag, "_frame_err"},   {31'd0, frame_err}, 0);
    check_eq({tag, "_err_code"},    {30'd0, err_code}, 0);
    check_eq({tag, "_frame_len"},   {27'd0, frame_len}, 0);
    check_eq({tag, "_busy"},        {31'd0, busy}, 0);
  endtask

  task automatic gen_random();
    int items, kind, len;
    logic [7:0] x, b;
    stream.delete();
    items = $urandom_range(1, 4);
    for (int it = 0; it < items; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        len = $urandom_range(1, 16);
        stream.push_back(8'hA5);
        stream.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          stream.push_back(b);
          x ^= b;
        end
        if (kind >= 5) x ^= 8'($urandom_range(1, 255));
        stream.push_back(x);
      end else if (kind == 7) begin
        stream.push_back(8'hA5);
        stream.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          stream.push_back(b);
        end
      end
    end
  endtask

  int pops0;

  initial begin
    reset     = 1'b0;
    rx_empty  = 1'b1;
    read_data = 8'h00;
    pl_addr   = 4'd0;
    repeat (3) cycle();
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (2) cycle();

    // Good frame
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    pops0 = pops;
    run_stream(0);
    check_eq("pop_count", pops - pops0, 6);

    // Bad checksum
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    run_stream(1);

    // Bad lengths followed by a one-byte good frame
    stream = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_stream(1);

    // Garbage ahead of a good frame
    stream = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    run_stream(2);

    // Timeout on a starved frame, then a new frame is accepted
    stream = '{8'hA5, 8'h02, 8'h11};
    run_stream(0);
    stream = '{8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFD};
    run_stream(1);

    // Reset in the middle of a frame
    fifo.push_back(8'hA5);
    fifo.push_back(8'h03);
    fifo.push_back(8'h11);
    refresh();
    for (int n = 0; n < 50 && (fifo.size() != 0 || read_uart); n++) cycle();
    repeat (2) cycle();
    check_eq("mid_frame_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    m_good = 0;
    m_bad = 0;
    m_drop = 0;
    m_last_len = 0;
    repeat (3) cycle();
    reset = 1'b1;
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    run_stream(1);

    // Randomized streams
    for (int r = 0; r < 30; r++) begin
      gen_random();
      run_stream(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
